bp_l15_req_sched: RTL and testbench
===================================

BP_L15_REQ_SCHED -- requirements
Module: bp_l15_req_sched

Interface
REQ-001 Parameter addr_width_p, default 40: request physical address width.
REQ-002 Parameter payload_width_p, default 16: opaque BP payload width carried to the response side.
REQ-003 Parameter max_outstanding_p, default 4: L1.5 requests in flight (acked, not retired); SHALL be >=1.
REQ-004 clk_i  input  1  sole clock; all state on rising edge.
REQ-005 reset_n_i  input  1  asynchronous, active-low reset.
REQ-006 cmd_v_i / cmd_rqtype_i[4:0] / cmd_size_i[2:0] / cmd_addr_i[addr_width_p] / cmd_payload_i[payload_width_p]  input  source 0, no-data request.
REQ-007 cmd_yumi_o  output  1  source 0 consumed this cycle.
REQ-008 data_cmd_v_i / data_cmd_rqtype_i[4:0] / data_cmd_size_i[2:0] / data_cmd_addr_i / data_cmd_data_i[64] / data_cmd_payload_i  input  source 1, request with store data.
REQ-009 data_cmd_yumi_o  output  1  source 1 consumed this cycle.
REQ-010 transducer_l15_val_o, _rqtype_o[4:0], _size_o[2:0], _address_o[addr_width_p], _data_o[64], _nc_o  output  request to L1.5.
REQ-011 l15_transducer_ack_i  input  1  L1.5 accepted the presented request.
REQ-012 resp_done_i  input  1  oldest outstanding request retired by response path.
REQ-013 resp_v_o / resp_src_o[1] / resp_payload_o[payload_width_p]  output  head of in-flight tag queue.
REQ-014 credits_o[clog2(max_outstanding_p+1)]  output  current outstanding count.
REQ-015 protocol_err_o  output  1  sticky protocol violation flag.

Function
REQ-016 FSM states e_idle, e_send; val_o SHALL equal (state==e_send).
REQ-017 Eligible = (any source valid) and (outstanding + pending-ack < max_outstanding_p).
REQ-018 e_idle and eligible: grant one source, assert its yumi that cycle, capture its fields into holding register, go e_send.
REQ-019 Both sources valid: grant the source not granted last (round-robin); after reset source 0 wins first.
REQ-020 e_send: all transducer_l15_* outputs SHALL stay stable from holding register until ack_i.
REQ-021 e_send and ack_i: push {src,payload} to tag queue, increment outstanding; if eligible (counting the just-acked request) capture next request same cycle and remain e_send, else go e_idle.
REQ-022 Sustained throughput: one request per cycle when L1.5 acks every cycle and credits allow.
REQ-023 Source 0 captures data_o = 0; nc_o SHALL always be 0.
REQ-024 ack_i in e_idle SHALL be ignored and set protocol_err_o.
REQ-025 resp_done_i pops tag queue, decrements outstanding; simultaneous push and pop leaves count unchanged.
REQ-026 resp_done_i with queue empty: no state change except protocol_err_o set.
REQ-027 Credits exhausted: no yumi asserted; val_o drops after the last pending ack; resumes the cycle after a resp_done_i frees a credit.
REQ-028 resp_v_o = queue non-empty; resp_src_o/resp_payload_o reflect oldest entry, combinationally from queue head.
REQ-029 No yumi SHALL assert without the capture occurring in the same cycle.

Reset
REQ-030 reset_n_i low: state=e_idle, val_o=0, yumis=0, outstanding=0, queue empty, last-grant=source 1, protocol_err_o=0, holding register=0, all outputs 0.
REQ-031 Reset asserted mid-e_send: request in holding register SHALL be discarded; upstream is responsible for reissue.

Structure
REQ-032 State enum, source encoding and PCX rqtype/size constants SHALL live in the shared bp_l15 package.
REQ-033 Tag queue SHALL be sub-module bp_l15_req_tag_fifo, depth max_outstanding_p, width payload_width_p+1, async active-low reset.

Verification
REQ-034 Only cmd_v_i, addr 0x80, ack after 3 cycles -> val_o 3 cycles, address_o stable 0x80, data_o 0, credits_o 1, resp_src_o 0.
REQ-035 Both valid continuously, ack every cycle -> grants alternate 0,1,0,1; one request per cycle.
REQ-036 max_outstanding_p=2, 3 requests, no resp_done -> 2 acked, third not yumied; one resp_done_i -> third issues next cycle.
REQ-037 ack_i and resp_done_i same cycle with credits_o=1 -> credits_o stays 1, queue head advances.
REQ-038 resp_done_i with empty queue -> protocol_err_o=1, credits_o stays 0.
REQ-039 reset_n_i low during e_send -> val_o 0 immediately, credits_o 0, resp_v_o 0.

Source files
------------

// File: rtl/bp_l15_pkg.sv
// Shared definitions for the BP -> L1.5 request path: FSM states, source IDs and PCX encodings.
package bp_l15_pkg;

    localparam logic [0:0] e_idle = 1'b0;
    localparam logic [0:0] e_send = 1'b1;

    typedef enum logic {
        e_src_cmd  = 1'b0,
        e_src_data = 1'b1
    } bp_l15_src_e;

    localparam logic [4:0] pcx_rqtype_load  = 5'b00000;
    localparam logic [4:0] pcx_rqtype_store = 5'b00001;

    localparam logic [2:0] pcx_size_1b = 3'b001;
    localparam logic [2:0] pcx_size_2b = 3'b010;
    localparam logic [2:0] pcx_size_4b = 3'b011;
    localparam logic [2:0] pcx_size_8b = 3'b100;

endpackage

// File: rtl/bp_l15_req_tag_fifo.sv
// In-flight tag queue: {src, payload} of every acked request, oldest entry shown at the head.
module bp_l15_req_tag_fifo #(
    parameter int depth_p = 4,
    parameter int width_p = 17
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic                             push_i,
    input  logic [width_p-1:0]               data_i,
    input  logic                             pop_i,
    output logic                             v_o,
    output logic [width_p-1:0]               data_o,
    output logic [$clog2(depth_p+1)-1:0]     count_o
);

    localparam int ptr_w_lp = (depth_p > 1) ? $clog2(depth_p) : 1;
    localparam int cnt_w_lp = $clog2(depth_p + 1);

    logic [width_p-1:0]  mem [depth_p];
    logic [ptr_w_lp-1:0] rd_ptr, wr_ptr;

    function automatic logic [ptr_w_lp-1:0] bump(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(depth_p - 1)) ? '0 : p + ptr_w_lp'(1);
    endfunction

    assign v_o    = (count_o != '0);
    assign data_o = mem[rd_ptr];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_o <= '0;
            for (int i = 0; i < depth_p; i++) mem[i] <= '0;
        end else begin
            if (push_i) begin
                mem[wr_ptr] <= data_i;
                wr_ptr      <= bump(wr_ptr);
            end
            if (pop_i) rd_ptr <= bump(rd_ptr);
            count_o <= count_o + cnt_w_lp'(push_i) - cnt_w_lp'(pop_i);
        end
    end

endmodule

// File: rtl/bp_l15_req_sched.sv
// Two-source round-robin request scheduler towards the L1.5 with credit-limited issue
// and an in-flight tag queue for the response path.
module bp_l15_req_sched
    import bp_l15_pkg::*;
#(
    parameter int addr_width_p      = 40,
    parameter int payload_width_p   = 16,
    parameter int max_outstanding_p = 4
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,

    input  logic                                   cmd_v_i,
    input  logic [4:0]                             cmd_rqtype_i,
    input  logic [2:0]                             cmd_size_i,
    input  logic [addr_width_p-1:0]                cmd_addr_i,
    input  logic [payload_width_p-1:0]             cmd_payload_i,
    output logic                                   cmd_yumi_o,

    input  logic                                   data_cmd_v_i,
    input  logic [4:0]                             data_cmd_rqtype_i,
    input  logic [2:0]                             data_cmd_size_i,
    input  logic [addr_width_p-1:0]                data_cmd_addr_i,
    input  logic [63:0]                            data_cmd_data_i,
    input  logic [payload_width_p-1:0]             data_cmd_payload_i,
    output logic                                   data_cmd_yumi_o,

    output logic                                   transducer_l15_val_o,
    output logic [4:0]                             transducer_l15_rqtype_o,
    output logic [2:0]                             transducer_l15_size_o,
    output logic [addr_width_p-1:0]                transducer_l15_address_o,
    output logic [63:0]                            transducer_l15_data_o,
    output logic                                   transducer_l15_nc_o,
    input  logic                                   l15_transducer_ack_i,

    input  logic                                   resp_done_i,
    output logic                                   resp_v_o,
    output logic                                   resp_src_o,
    output logic [payload_width_p-1:0]             resp_payload_o,
    output logic [$clog2(max_outstanding_p+1)-1:0] credits_o,
    output logic                                   protocol_err_o
);

    logic [0:0]                 state;
    bp_l15_src_e                last_grant, grant, hold_src;
    logic [4:0]                 hold_rqtype;
    logic [2:0]                 hold_size;
    logic [addr_width_p-1:0]    hold_addr;
    logic [63:0]                hold_data;
    logic [payload_width_p-1:0] hold_payload;
    logic [payload_width_p:0]   head;
    logic                       pending, ack, eligible, capture, pop;

    // The presented-but-unacked request consumes a credit; once acked it moves into the queue.
    assign pending  = (state == e_send);
    assign ack      = pending && l15_transducer_ack_i;
    assign eligible = (cmd_v_i || data_cmd_v_i)
                   && (int'(credits_o) + int'(pending) < max_outstanding_p);
    assign capture  = eligible && (!pending || ack);
    assign grant    = (data_cmd_v_i && (!cmd_v_i || last_grant == e_src_cmd)) ? e_src_data : e_src_cmd;
    assign pop      = resp_done_i && resp_v_o;

    assign cmd_yumi_o      = capture && (grant == e_src_cmd);
    assign data_cmd_yumi_o = capture && (grant == e_src_data);

    assign transducer_l15_val_o     = pending;
    assign transducer_l15_rqtype_o  = hold_rqtype;
    assign transducer_l15_size_o    = hold_size;
    assign transducer_l15_address_o = hold_addr;
    assign transducer_l15_data_o    = hold_data;
    assign transducer_l15_nc_o      = 1'b0;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state          <= e_idle;
            last_grant     <= e_src_data;
            protocol_err_o <= 1'b0;
            hold_src       <= e_src_cmd;
            hold_rqtype    <= '0;
            hold_size      <= '0;
            hold_addr      <= '0;
            hold_data      <= '0;
            hold_payload   <= '0;
        end else begin
            if (capture) begin
                state      <= e_send;
                last_grant <= grant;
                hold_src   <= grant;
                if (grant == e_src_data) begin
                    hold_rqtype  <= data_cmd_rqtype_i;
                    hold_size    <= data_cmd_size_i;
                    hold_addr    <= data_cmd_addr_i;
                    hold_data    <= data_cmd_data_i;
                    hold_payload <= data_cmd_payload_i;
                end else begin
                    hold_rqtype  <= cmd_rqtype_i;
                    hold_size    <= cmd_size_i;
                    hold_addr    <= cmd_addr_i;
                    hold_data    <= '0;
                    hold_payload <= cmd_payload_i;
                end
            end else if (ack) begin
                state <= e_idle;
            end
            if ((l15_transducer_ack_i && !pending) || (resp_done_i && !resp_v_o))
                protocol_err_o <= 1'b1;
        end
    end

    bp_l15_req_tag_fifo #(
        .depth_p (max_outstanding_p),
        .width_p (payload_width_p + 1)
    ) tag_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .push_i    (ack),
        .data_i    ({hold_src, hold_payload}),
        .pop_i     (pop),
        .v_o       (resp_v_o),
        .data_o    (head),
        .count_o   (credits_o)
    );

    assign resp_src_o     = head[payload_width_p];
    assign resp_payload_o = head[payload_width_p-1:0];

endmodule

// File: tb/tb_bp_l15_req_sched.sv
// Directed and random checks of bp_l15_req_sched against a transaction-level queue model;
// instance a uses 4 credits, instance b uses 2 credits.
module tb_bp_l15_req_sched;
    localparam int AW = 40;
    localparam int PW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          cmd_v = 0, dcmd_v = 0, ack = 0, done = 0;
    logic [4:0]    cmd_rqt = 0, dcmd_rqt = 0;
    logic [2:0]    cmd_size = 0, dcmd_size = 0;
    logic [AW-1:0] cmd_addr = 0, dcmd_addr = 0;
    logic [PW-1:0] cmd_pay = 0, dcmd_pay = 0;
    logic [63:0]   dcmd_data = 0;

    logic a_cy, a_dy, a_val, a_nc, a_rv, a_rsrc, a_err;
    logic b_cy, b_dy, b_val, b_nc, b_rv, b_rsrc, b_err;
    logic [4:0] a_rqt, b_rqt;
    logic [2:0] a_size, b_size, a_cred;
    logic [1:0] b_cred;
    logic [AW-1:0] a_addr, b_addr;
    logic [63:0] a_data, b_data;
    logic [PW-1:0] a_rpay, b_rpay;

    bp_l15_req_sched #(.addr_width_p(AW), .payload_width_p(PW), .max_outstanding_p(4)) u_a (
        .clk_i(clk), .reset_n_i(rst_n),
        .cmd_v_i(cmd_v), .cmd_rqtype_i(cmd_rqt), .cmd_size_i(cmd_size), .cmd_addr_i(cmd_addr),
        .cmd_payload_i(cmd_pay), .cmd_yumi_o(a_cy),
        .data_cmd_v_i(dcmd_v), .data_cmd_rqtype_i(dcmd_rqt), .data_cmd_size_i(dcmd_size),
        .data_cmd_addr_i(dcmd_addr), .data_cmd_data_i(dcmd_data), .data_cmd_payload_i(dcmd_pay),
        .data_cmd_yumi_o(a_dy),
        .transducer_l15_val_o(a_val), .transducer_l15_rqtype_o(a_rqt), .transducer_l15_size_o(a_size),
        .transducer_l15_address_o(a_addr), .transducer_l15_data_o(a_data), .transducer_l15_nc_o(a_nc),
        .l15_transducer_ack_i(ack), .resp_done_i(done), .resp_v_o(a_rv), .resp_src_o(a_rsrc),
        .resp_payload_o(a_rpay), .credits_o(a_cred), .protocol_err_o(a_err));

    bp_l15_req_sched #(.addr_width_p(AW), .payload_width_p(PW), .max_outstanding_p(2)) u_b (
        .clk_i(clk), .reset_n_i(rst_n),
        .cmd_v_i(cmd_v), .cmd_rqtype_i(cmd_rqt), .cmd_size_i(cmd_size), .cmd_addr_i(cmd_addr),
        .cmd_payload_i(cmd_pay), .cmd_yumi_o(b_cy),
        .data_cmd_v_i(dcmd_v), .data_cmd_rqtype_i(dcmd_rqt), .data_cmd_size_i(dcmd_size),
        .data_cmd_addr_i(dcmd_addr), .data_cmd_data_i(dcmd_data), .data_cmd_payload_i(dcmd_pay),
        .data_cmd_yumi_o(b_dy),
        .transducer_l15_val_o(b_val), .transducer_l15_rqtype_o(b_rqt), .transducer_l15_size_o(b_size),
        .transducer_l15_address_o(b_addr), .transducer_l15_data_o(b_data), .transducer_l15_nc_o(b_nc),
        .l15_transducer_ack_i(ack), .resp_done_i(done), .resp_v_o(b_rv), .resp_src_o(b_rsrc),
        .resp_payload_o(b_rpay), .credits_o(b_cred), .protocol_err_o(b_err));

    // Observed outputs of whichever instance is under test.
    logic sel = 0;
    logic o_cy, o_dy, o_val, o_nc, o_rv, o_rsrc, o_err;
    logic [4:0] o_rqt; logic [2:0] o_size; logic [AW-1:0] o_addr; logic [63:0] o_data;
    logic [PW-1:0] o_rpay; int o_cred;
    always_comb begin
        o_cy = sel ? b_cy : a_cy;       o_dy = sel ? b_dy : a_dy;
        o_val = sel ? b_val : a_val;    o_nc = sel ? b_nc : a_nc;
        o_rv = sel ? b_rv : a_rv;       o_rsrc = sel ? b_rsrc : a_rsrc;
        o_err = sel ? b_err : a_err;    o_rqt = sel ? b_rqt : a_rqt;
        o_size = sel ? b_size : a_size; o_addr = sel ? b_addr : a_addr;
        o_data = sel ? b_data : a_data; o_rpay = sel ? b_rpay : a_rpay;
        o_cred = sel ? int'(b_cred) : int'(a_cred);
    end

    typedef struct {
        logic src; logic [4:0] rqt; logic [2:0] size;
        logic [AW-1:0] addr; logic [63:0] data; logic [PW-1:0] pay;
    } req_t;

    req_t pend[$];
    req_t infl[$];
    bit   last_g, m_err, took_c, took_d, seen_val, seen_cy, seen_dy;
    int   max_o = 4;
    int   n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic new_cmd();
        cmd_rqt = 5'($urandom); cmd_size = 3'($urandom);
        cmd_addr = AW'({$urandom(), $urandom()}); cmd_pay = PW'($urandom);
    endtask

    task automatic new_dcmd();
        dcmd_rqt = 5'($urandom); dcmd_size = 3'($urandom);
        dcmd_addr = AW'({$urandom(), $urandom()}); dcmd_pay = PW'($urandom);
        dcmd_data = {$urandom(), $urandom()};
    endtask

    // One clock: check combinational outputs against the model, clock, then check state outputs.
    task automatic step();
        bit elig, gd;
        req_t r;
        #1;
        gd   = dcmd_v && (!cmd_v || last_g == 1'b0);
        elig = (cmd_v || dcmd_v) && (infl.size() + pend.size() < max_o) && (pend.size() == 0 || ack);
        seen_val = o_val; seen_cy = o_cy; seen_dy = o_dy;
        chk("val", o_val, pend.size() != 0);
        chk("nc", o_nc, 0);
        chk("cmd_yumi", o_cy, elig && !gd);
        chk("data_yumi", o_dy, elig && gd);
        if (pend.size() != 0) begin
            chk("address", o_addr, pend[0].addr);
            chk("data", o_data, pend[0].data);
            chk("rqtype_size", {o_rqt, o_size}, {pend[0].rqt, pend[0].size});
        end
        @(posedge clk);
        if (done) begin
            if (infl.size() != 0) void'(infl.pop_front()); else m_err = 1;
        end
        if (ack) begin
            if (pend.size() != 0) infl.push_back(pend.pop_front()); else m_err = 1;
        end
        took_c = elig && !gd;
        took_d = elig && gd;
        if (elig) begin
            r.src  = gd;
            r.rqt  = gd ? dcmd_rqt : cmd_rqt;
            r.size = gd ? dcmd_size : cmd_size;
            r.addr = gd ? dcmd_addr : cmd_addr;
            r.data = gd ? dcmd_data : 64'd0;
            r.pay  = gd ? dcmd_pay : cmd_pay;
            pend.push_back(r);
            last_g = gd;
        end
        #1;
        chk("credits", o_cred, infl.size());
        chk("resp_v", o_rv, infl.size() != 0);
        chk("protocol_err", o_err, m_err);
        if (infl.size() != 0) begin
            chk("resp_src", o_rsrc, infl[0].src);
            chk("resp_payload", o_rpay, infl[0].pay);
        end
    endtask

    task automatic do_reset();
        rst_n = 0; cmd_v = 0; dcmd_v = 0; ack = 0; done = 0;
        #1;
        chk("rst_val", o_val, 0);
        chk("rst_yumi", {o_cy, o_dy}, 0);
        chk("rst_credits", o_cred, 0);
        chk("rst_resp_v", o_rv, 0);
        chk("rst_err", o_err, 0);
        chk("rst_hold", {o_addr, o_rqt, o_size}, 0);
        chk("rst_data", o_data, 0);
        chk("rst_resp", {o_rsrc, o_rpay}, 0);
        @(posedge clk); #1;
        rst_n = 1;
        pend.delete(); infl.delete(); last_g = 1; m_err = 0;
    endtask

    initial begin
        int nval, ny;
        logic [PW-1:0] second_pay;

        // Single no-data request, ack on the third presented cycle
        sel = 0; max_o = 4;
        do_reset();
        cmd_v = 1; cmd_addr = 'h80; cmd_rqt = 5'b00000; cmd_size = 3'b100; cmd_pay = 'h1234;
        step();
        chk("t1_yumi", seen_cy, 1);
        cmd_v = 0; nval = 0;
        for (int i = 0; i < 4; i++) begin
            ack = (i == 2);
            step();
            nval += int'(seen_val);
            if (seen_val) chk("t1_addr", o_addr, 'h80);
        end
        ack = 0;
        chk("t1_val_cycles", nval, 3);
        chk("t1_credits", o_cred, 1);
        chk("t1_resp_src", o_rsrc, 0);

        // Ack and resp_done together with one outstanding
        cmd_v = 1; new_cmd(); second_pay = cmd_pay;
        step();
        cmd_v = 0; ack = 1; done = 1;
        step();
        ack = 0; done = 0;
        chk("t3_credits", o_cred, 1);
        chk("t3_head", o_rpay, second_pay);
        done = 1; step(); done = 0;
        chk("t3_drain", o_cred, 0);

        // resp_done with empty queue
        done = 1; step(); done = 0;
        chk("t4_err", o_err, 1);
        chk("t4_credits", o_cred, 0);

        // Round robin at full rate
        do_reset();
        new_cmd(); new_dcmd(); cmd_v = 1; dcmd_v = 1;
        for (int i = 0; i < 8; i++) begin
            ack = (pend.size() != 0);
            done = (infl.size() != 0);
            step();
            chk("t2_grant", {seen_cy, seen_dy}, (i % 2 == 0) ? 2'b10 : 2'b01);
            if (took_c) new_cmd();
            if (took_d) new_dcmd();
        end

        // Reset while a request is presented
        ack = 0; done = 0;
        chk("t6_presenting", o_val, 1);
        do_reset();

        // Two credits: third request stalls until a retirement
        sel = 1; max_o = 2;
        do_reset();
        new_cmd(); cmd_v = 1; ny = 0;
        for (int i = 0; i < 6; i++) begin
            ack = (pend.size() != 0);
            step();
            ny += int'(seen_cy);
            if (took_c) new_cmd();
        end
        ack = 0;
        chk("t5_issued", ny, 2);
        chk("t5_credits", o_cred, 2);
        chk("t5_val_off", o_val, 0);
        done = 1; step(); done = 0;
        chk("t5_no_yumi_same_cycle", seen_cy, 0);
        step();
        chk("t5_resume", seen_cy, 1);
        if (took_c) new_cmd();

        // Random traffic on both configurations
        for (int pass = 0; pass < 2; pass++) begin
            sel = pass[0]; max_o = pass ? 2 : 4;
            do_reset();
            for (int c = 0; c < 1500; c++) begin
                if (!cmd_v) begin new_cmd(); cmd_v = ($urandom_range(0, 2) != 0); end
                if (!dcmd_v) begin new_dcmd(); dcmd_v = ($urandom_range(0, 2) != 0); end
                ack  = (pend.size() != 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 63) == 0);
                done = (infl.size() != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 63) == 0);
                step();
                if (took_c) cmd_v = 0;
                if (took_d) dcmd_v = 0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
